// File: rtl/spy_round_controller.sv
// Round sequencer for the two-player code-guessing game: P1 code entry, P2 timed guessing, scoring, game end.
// Optional `SPY_PAUSE_EN adds a level pause input that freezes GUESS/RETRY/RESULT.
module spy_round_controller #(
    parameter int CODE_W      = 20,
    parameter int TIME_LIMIT  = 30,
    parameter int MAX_TRIES   = 3,
    parameter int ROUNDS      = 5,
    parameter int RESULT_HOLD = 3
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              tick,
    input  logic              start,
    input  logic              p1_done,
    input  logic [CODE_W-1:0] p1_value,
    input  logic              p2_done,
    input  logic              p2_correct,
`ifdef SPY_PAUSE_EN
    input  logic              pause,
`endif
    output logic [CODE_W-1:0] code_out,
    output logic              p1_enable,
    output logic              p2_enable,
    output logic              p2_clear,
    output logic [7:0]        time_left,
    output logic [3:0]        tries_left,
    output logic [3:0]        round_num,
    output logic [3:0]        p1_score,
    output logic [3:0]        p2_score,
    output logic              round_win,
    output logic              round_lose,
    output logic              game_over,
    output logic [1:0]        winner,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        P1_ENTRY = 3'd1,
        ARM      = 3'd2,
        GUESS    = 3'd3,
        RETRY    = 3'd4,
        RESULT   = 3'd5,
        OVER     = 3'd6
    } state_t;

    localparam logic [7:0] TIME_INIT  = 8'(TIME_LIMIT);
    localparam logic [3:0] TRIES_INIT = 4'(MAX_TRIES);
    localparam logic [3:0] HOLD_INIT  = 4'(RESULT_HOLD);
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    state_t            state_q, state_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [7:0]        time_q, time_d;
    logic [3:0]        tries_q, tries_d;
    logic [3:0]        round_q, round_d;
    logic [3:0]        p1s_q, p1s_d;
    logic [3:0]        p2s_q, p2s_d;
    logic [3:0]        hold_q, hold_d;
    logic              win_q, win_d;
    logic              lose_q, lose_d;
    logic [1:0]        winner_q, winner_d;

    logic paused;
    logic do_timer;
    logic lose_round;

`ifdef SPY_PAUSE_EN
    assign paused = pause && (state_q == GUESS || state_q == RETRY || state_q == RESULT);
`else
    assign paused = 1'b0;
`endif

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        time_d     = time_q;
        tries_d    = tries_q;
        round_d    = round_q;
        p1s_d      = p1s_q;
        p2s_d      = p2s_q;
        hold_d     = hold_q;
        win_d      = win_q;
        lose_d     = lose_q;
        winner_d   = winner_q;
        do_timer   = 1'b0;
        lose_round = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = P1_ENTRY;
                    p1s_d   = 4'd0;
                    p2s_d   = 4'd0;
                    round_d = 4'd0;
                end
            end
            P1_ENTRY: begin
                if (p1_done) begin
                    code_d  = p1_value;
                    state_d = ARM;
                end
            end
            ARM: begin
                time_d  = TIME_INIT;
                tries_d = TRIES_INIT;
                state_d = GUESS;
            end
            GUESS: begin
                if (!paused) begin
                    // A guess wins the cycle; a coincident tick is dropped.
                    if (p2_done) begin
                        if (p2_correct) begin
                            p2s_d   = sat_inc(p2s_q);
                            win_d   = 1'b1;
                            hold_d  = HOLD_INIT;
                            state_d = RESULT;
                        end else if (tries_q <= 4'd1) begin
                            tries_d    = 4'd0;
                            lose_round = 1'b1;
                        end else begin
                            tries_d = tries_q - 4'd1;
                            state_d = RETRY;
                        end
                    end else begin
                        do_timer = tick;
                    end
                end
            end
            RETRY: begin
                if (!paused) begin
                    state_d  = GUESS;
                    do_timer = tick;
                end
            end
            RESULT: begin
                if (!paused && tick) begin
                    if (hold_q <= 4'd1) begin
                        hold_d = 4'd0;
                        win_d  = 1'b0;
                        lose_d = 1'b0;
                        if (round_q == LAST_ROUND) begin
                            state_d = OVER;
                            if (p1s_q > p2s_q)      winner_d = 2'b01;
                            else if (p2s_q > p1s_q) winner_d = 2'b10;
                            else                    winner_d = 2'b11;
                        end else begin
                            round_d = round_q + 4'd1;
                            state_d = P1_ENTRY;
                        end
                    end else begin
                        hold_d = hold_q - 4'd1;
                    end
                end
            end
            OVER: begin
                if (start) begin
                    p1s_d    = 4'd0;
                    p2s_d    = 4'd0;
                    round_d  = 4'd0;
                    winner_d = 2'b00;
                    state_d  = P1_ENTRY;
                end
            end
            default: state_d = IDLE;
        endcase

        // Countdown shared by GUESS and RETRY; expiry overrides the RETRY->GUESS hop.
        if (do_timer) begin
            if (time_q <= 8'd1) begin
                time_d     = 8'd0;
                lose_round = 1'b1;
            end else begin
                time_d = time_q - 8'd1;
            end
        end

        if (lose_round) begin
            p1s_d   = sat_inc(p1s_q);
            lose_d  = 1'b1;
            hold_d  = HOLD_INIT;
            state_d = RESULT;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= IDLE;
            code_q   <= '0;
            time_q   <= 8'd0;
            tries_q  <= 4'd0;
            round_q  <= 4'd0;
            p1s_q    <= 4'd0;
            p2s_q    <= 4'd0;
            hold_q   <= 4'd0;
            win_q    <= 1'b0;
            lose_q   <= 1'b0;
            winner_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            code_q   <= code_d;
            time_q   <= time_d;
            tries_q  <= tries_d;
            round_q  <= round_d;
            p1s_q    <= p1s_d;
            p2s_q    <= p2s_d;
            hold_q   <= hold_d;
            win_q    <= win_d;
            lose_q   <= lose_d;
            winner_q <= winner_d;
        end
    end

    assign state      = state_q;
    assign code_out   = code_q;
    assign time_left  = time_q;
    assign tries_left = tries_q;
    assign round_num  = round_q;
    assign p1_score   = p1s_q;
    assign p2_score   = p2s_q;
    assign round_win  = win_q;
    assign round_lose = lose_q;
    assign winner     = winner_q;
    assign p1_enable  = (state_q == P1_ENTRY);
    assign p2_enable  = (state_q == GUESS) && !paused;
    assign p2_clear   = (state_q == ARM) || (state_q == RETRY);
    assign game_over  = (state_q == OVER);

endmodule

// File: tb/tb_spy_round_controller.sv
// Directed bench for spy_round_controller with a short game (5 s, 2 tries, 2 rounds, hold 2).
module tb_spy_round_controller;

    localparam int CODE_W = 20;

    logic              clock = 1'b0;
    logic              resetn, tick, start, p1_done, p2_done, p2_correct;
    logic [CODE_W-1:0] p1_value;
`ifdef SPY_PAUSE_EN
    logic              pause;
`endif
    logic [CODE_W-1:0] code_out;
    logic              p1_enable, p2_enable, p2_clear;
    logic [7:0]        time_left;
    logic [3:0]        tries_left, round_num, p1_score, p2_score;
    logic              round_win, round_lose, game_over;
    logic [1:0]        winner;
    logic [2:0]        state;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    spy_round_controller #(
        .CODE_W(CODE_W), .TIME_LIMIT(5), .MAX_TRIES(2), .ROUNDS(2), .RESULT_HOLD(2)
    ) dut (
        .clock(clock), .resetn(resetn), .tick(tick), .start(start),
        .p1_done(p1_done), .p1_value(p1_value), .p2_done(p2_done), .p2_correct(p2_correct),
`ifdef SPY_PAUSE_EN
        .pause(pause),
`endif
        .code_out(code_out), .p1_enable(p1_enable), .p2_enable(p2_enable), .p2_clear(p2_clear),
        .time_left(time_left), .tries_left(tries_left), .round_num(round_num),
        .p1_score(p1_score), .p2_score(p2_score), .round_win(round_win), .round_lose(round_lose),
        .game_over(game_over), .winner(winner), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, pulses dropped.
    task automatic step();
        @(posedge clock);
        #1;
        tick = 1'b0; start = 1'b0; p1_done = 1'b0; p2_done = 1'b0; p2_correct = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; tick = 1'b0; start = 1'b0; p1_done = 1'b0;
        p2_done = 1'b0; p2_correct = 1'b0; p1_value = '0;
`ifdef SPY_PAUSE_EN
        pause = 1'b0;
`endif
        step(); step();
        chk("reset_state", 32'(state), 0);
        resetn = 1'b1;

        // Get into GUESS, then reset mid-round
        start = 1'b1; step();
        p1_value = 20'h55; p1_done = 1'b1; step();
        step();
        chk("pre_rst_guess", 32'(state), 3);
        resetn = 1'b0; step(); step();
        resetn = 1'b1;
        chk("rst_state", 32'(state), 0);
        chk("rst_code", 32'(code_out), 0);
        chk("rst_time", 32'(time_left), 0);
        chk("rst_tries", 32'(tries_left), 0);
        chk("rst_enables", {29'd0, p1_enable, p2_enable, p2_clear}, 0);
        chk("rst_game_over", 32'(game_over), 0);

        // Round 0: player 2 guesses correctly first try
        start = 1'b1; step();
        chk("r0_p1_entry", 32'(state), 1);
        chk("r0_p1_enable", 32'(p1_enable), 1);
        p2_done = 1'b1; p2_correct = 1'b1; step();
        chk("r0_p2_ignored", 32'(state), 1);
        p1_value = 20'h2E; p1_done = 1'b1; step();
        chk("r0_arm", 32'(state), 2);
        chk("r0_clear_hi", 32'(p2_clear), 1);
        chk("r0_code", 32'(code_out), 32'h2E);
        step();
        chk("r0_clear_lo", 32'(p2_clear), 0);
        chk("r0_time_init", 32'(time_left), 5);
        chk("r0_tries_init", 32'(tries_left), 2);
        chk("r0_p2_enable", 32'(p2_enable), 1);
        p2_done = 1'b1; p2_correct = 1'b1; step();
        chk("r0_result", 32'(state), 5);
        chk("r0_p2_score", 32'(p2_score), 1);
        chk("r0_win", 32'(round_win), 1);
        tick = 1'b1; step();
        chk("r0_hold1", 32'(state), 5);
        tick = 1'b1; step();
        chk("r0_next_state", 32'(state), 1);
        chk("r0_round_num", 32'(round_num), 1);
        chk("r0_win_clr", 32'(round_win), 0);

        // Round 1: two wrong guesses
        p1_value = 20'h1234; p1_done = 1'b1; step();
        step();
        p2_done = 1'b1; step();
        chk("r1_retry", 32'(state), 4);
        chk("r1_tries1", 32'(tries_left), 1);
        chk("r1_retry_clear", 32'(p2_clear), 1);
        step();
        chk("r1_back_guess", 32'(state), 3);
        chk("r1_clear_lo", 32'(p2_clear), 0);
        p2_done = 1'b1; step();
        chk("r1_tries0", 32'(tries_left), 0);
        chk("r1_p1_score", 32'(p1_score), 1);
        chk("r1_lose", 32'(round_lose), 1);
        tick = 1'b1; step();
        tick = 1'b1; step();
        chk("over_state", 32'(state), 6);
        chk("over_flag", 32'(game_over), 1);
        chk("over_winner", 32'(winner), 3);
        chk("over_code_hold", 32'(code_out), 32'h1234);
        start = 1'b1; step();
        chk("restart_state", 32'(state), 1);
        chk("restart_scores", {24'd0, p1_score, p2_score}, 0);
        chk("restart_winner", 32'(winner), 0);
        chk("restart_round", 32'(round_num), 0);

        // Timer round: combined guess+tick, then expiry
        p1_value = 20'hABCDE; p1_done = 1'b1; step();
        step();
        p2_done = 1'b1; tick = 1'b1; step();
        chk("combo_time", 32'(time_left), 5);
        chk("combo_tries", 32'(tries_left), 1);
        step();
        chk("combo_guess", 32'(state), 3);
`ifdef SPY_PAUSE_EN
        pause = 1'b1;
        #1;
        chk("pause_p2_enable", 32'(p2_enable), 0);
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; p2_done = (i == 1); step();
        end
        chk("pause_time", 32'(time_left), 5);
        chk("pause_tries", 32'(tries_left), 1);
        chk("pause_state", 32'(state), 3);
        pause = 1'b0;
        #1;
        chk("unpause_p2_enable", 32'(p2_enable), 1);
`endif
        for (int i = 1; i <= 5; i++) begin
            tick = 1'b1; step();
            chk($sformatf("timer_%0d", i), 32'(time_left), 32'(5 - i));
        end
        chk("timeout_state", 32'(state), 5);
        chk("timeout_lose", 32'(round_lose), 1);
        chk("timeout_p1_score", 32'(p1_score), 1);
        chk("timeout_winner_idle", 32'(winner), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
